// File: rtl/pc_unit_if.sv
// Bus bundle between the next-PC logic (master) and the program-counter unit (slave).
interface pc_unit_if #(
  parameter int unsigned XLEN = 32
);
  // Control from the next-PC logic.
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            call;
  logic [XLEN-1:0] call_target;
  logic            ret;
  logic            halt_req;
  logic            resume;

  // Status and fetch address from the PC unit.
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            pc_valid;
  logic            halted;
  logic            misaligned;
  logic [XLEN-1:0] fault_addr;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_underflow;

  modport master (
    output stall, redirect_valid, redirect_target, call, call_target, ret,
           halt_req, resume,
    input  pc, pc_plus4, pc_valid, halted, misaligned, fault_addr,
           ras_empty, ras_full, ras_underflow
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, call, call_target, ret,
           halt_req, resume,
    output pc, pc_plus4, pc_valid, halted, misaligned, fault_addr,
           ras_empty, ras_full, ras_underflow
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC selection, circular return-address
// stack, debug halt/resume and sticky misaligned-fetch fault.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic clk,
  input  logic rst,
  pc_unit_if.slave bus
);
  localparam int unsigned      PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned      CNT_W    = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  logic [1:0]       r_state;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_fault_addr;
  logic [XLEN-1:0]  r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_top;     // next free slot; top-of-stack is r_top-1
  logic [CNT_W-1:0] r_count;
  logic             r_underflow;

  logic             w_run;
  logic [XLEN-1:0]  w_pc_plus4;
  logic [XLEN-1:0]  w_next_pc;
  logic [XLEN-1:0]  w_ras_top;
  logic [PTR_W-1:0] w_top_m1;
  logic             w_push;
  logic             w_pop;
  logic             w_underflow;
  logic             w_misaligned;

  assign w_run      = (r_state == ST_RUN);
  assign w_pc_plus4 = r_pc + XLEN'(4);
  assign w_top_m1   = r_top - 1'b1;
  assign w_ras_top  = r_ras[w_top_m1];

  // Next-PC priority select and RAS push/pop decision for the RUN state.
  always_comb begin
    w_next_pc   = w_pc_plus4;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_underflow = 1'b0;
    if (bus.redirect_valid) begin
      w_next_pc = bus.redirect_target;
    end else if (bus.stall) begin
      w_next_pc = r_pc;
    end else if (bus.ret) begin
      if (r_count != '0) begin
        w_next_pc = w_ras_top;
        w_pop     = 1'b1;
      end else begin
        w_underflow = 1'b1;
      end
    end else if (bus.call) begin
      w_next_pc = bus.call_target;
      w_push    = 1'b1;
    end
    // A faulting target must leave the stack untouched, so gate the RAS ops here.
    w_misaligned = w_run && (w_next_pc[1:0] != 2'b00);
    if (!w_run || w_misaligned) begin
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_underflow = 1'b0;
    end
  end

  // State machine, PC register, fault capture, RAS pointers and underflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_VECTOR;
      r_fault_addr <= '0;
      r_top        <= '0;
      r_count      <= '0;
      r_underflow  <= 1'b0;
    end else begin
      r_underflow <= w_underflow;
      case (r_state)
        ST_RUN: begin
          if (w_misaligned) begin
            r_state      <= ST_FAULT;
            r_fault_addr <= w_next_pc;
          end else begin
            r_pc <= w_next_pc;
            if (bus.halt_req) r_state <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          if (bus.resume) r_state <= ST_RUN;
        end
        default: r_state <= ST_FAULT;
      endcase
      if (w_push) begin
        r_top <= r_top + 1'b1;
        if (r_count != FULL_CNT) r_count <= r_count + 1'b1;
      end else if (w_pop) begin
        r_top   <= w_top_m1;
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Stack storage; a push when full lands on the oldest entry because r_top wraps onto it.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_ras[r_top] <= w_pc_plus4;
  end

  assign bus.pc            = r_pc;
  assign bus.pc_plus4      = w_pc_plus4;
  assign bus.pc_valid      = w_run && !bus.stall;
  assign bus.halted        = (r_state == ST_HALTED);
  assign bus.misaligned    = (r_state == ST_FAULT);
  assign bus.fault_addr    = r_fault_addr;
  assign bus.ras_empty     = (r_count == '0);
  assign bus.ras_full      = (r_count == FULL_CNT);
  assign bus.ras_underflow = r_underflow;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: table of per-cycle vectors with a scoreboard
// queue, followed by hand-written pc_valid checks.
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(32)) bus ();

  pc_unit #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Control bits
  localparam logic [6:0] K_RST = 7'b0000001;
  localparam logic [6:0] K_STL = 7'b0000010;
  localparam logic [6:0] K_RED = 7'b0000100;
  localparam logic [6:0] K_CAL = 7'b0001000;
  localparam logic [6:0] K_RET = 7'b0010000;
  localparam logic [6:0] K_HLT = 7'b0100000;
  localparam logic [6:0] K_RES = 7'b1000000;
  // Expected flag bits
  localparam logic [4:0] F_HLT = 5'b10000;
  localparam logic [4:0] F_MIS = 5'b01000;
  localparam logic [4:0] F_EMP = 5'b00100;
  localparam logic [4:0] F_FUL = 5'b00010;
  localparam logic [4:0] F_UF  = 5'b00001;

  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] tgt;
    logic [31:0] ctgt;
    logic [31:0] exp_pc;
    logic [4:0]  exp_flags;
    logic [31:0] exp_fa;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int unsigned n_vec = 0;
  int unsigned n_miss = 0;

  function automatic vec_t mk(logic [6:0] ctl, logic [31:0] tgt, logic [31:0] ctgt,
                              logic [31:0] epc, logic [4:0] fl, logic [31:0] efa);
    vec_t v;
    v.ctl = ctl; v.tgt = tgt; v.ctgt = ctgt;
    v.exp_pc = epc; v.exp_flags = fl; v.exp_fa = efa;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] ctl, input logic [31:0] tgt, input logic [31:0] ctgt);
    rst                 = ctl[0];
    bus.stall           = ctl[1];
    bus.redirect_valid  = ctl[2];
    bus.call            = ctl[3];
    bus.ret             = ctl[4];
    bus.halt_req        = ctl[5];
    bus.resume          = ctl[6];
    bus.redirect_target = tgt;
    bus.call_target     = ctgt;
  endtask

  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v.ctl, v.tgt, v.ctgt);
    sb.push_back(v);
    n_vec++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("v%0d pc", idx), bus.pc, e.exp_pc);
    check($sformatf("v%0d pc_plus4", idx), bus.pc_plus4, e.exp_pc + 32'd4);
    check($sformatf("v%0d halted", idx), 32'(bus.halted), 32'(e.exp_flags[4]));
    check($sformatf("v%0d misaligned", idx), 32'(bus.misaligned), 32'(e.exp_flags[3]));
    check($sformatf("v%0d ras_empty", idx), 32'(bus.ras_empty), 32'(e.exp_flags[2]));
    check($sformatf("v%0d ras_full", idx), 32'(bus.ras_full), 32'(e.exp_flags[1]));
    check($sformatf("v%0d ras_underflow", idx), 32'(bus.ras_underflow), 32'(e.exp_flags[0]));
    check($sformatf("v%0d fault_addr", idx), bus.fault_addr, e.exp_fa);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(K_RST, '0, '0);
    // Reset and free-run
    vecs.push_back(mk(K_RST, 0, 0, 32'h0, F_EMP, 0));
    vecs.push_back(mk(0, 0, 0, 32'h4, F_EMP, 0));
    vecs.push_back(mk(0, 0, 0, 32'h8, F_EMP, 0));
    vecs.push_back(mk(0, 0, 0, 32'hC, F_EMP, 0));
    vecs.push_back(mk(0, 0, 0, 32'h10, F_EMP, 0));
    // Stall, then redirect overriding stall
    vecs.push_back(mk(K_STL, 0, 0, 32'h10, F_EMP, 0));
    vecs.push_back(mk(K_STL, 0, 0, 32'h10, F_EMP, 0));
    vecs.push_back(mk(K_STL | K_RED, 32'h40, 0, 32'h40, F_EMP, 0));
    // Single call / return
    vecs.push_back(mk(K_RED, 32'h20, 0, 32'h20, F_EMP, 0));
    vecs.push_back(mk(K_CAL, 0, 32'h100, 32'h100, 0, 0));
    vecs.push_back(mk(K_RET, 0, 0, 32'h24, F_EMP, 0));
    // Five nested calls overflow the 4-deep stack, oldest (0x28) lost
    vecs.push_back(mk(K_CAL, 0, 32'h200, 32'h200, 0, 0));
    vecs.push_back(mk(K_CAL, 0, 32'h300, 32'h300, 0, 0));
    vecs.push_back(mk(K_CAL, 0, 32'h400, 32'h400, 0, 0));
    vecs.push_back(mk(K_CAL, 0, 32'h500, 32'h500, F_FUL, 0));
    vecs.push_back(mk(K_CAL, 0, 32'h600, 32'h600, F_FUL, 0));
    vecs.push_back(mk(K_RET, 0, 0, 32'h504, 0, 0));
    vecs.push_back(mk(K_RET, 0, 0, 32'h404, 0, 0));
    vecs.push_back(mk(K_RET, 0, 0, 32'h304, 0, 0));
    vecs.push_back(mk(K_RET, 0, 0, 32'h204, F_EMP, 0));
    vecs.push_back(mk(K_RET, 0, 0, 32'h208, F_EMP | F_UF, 0));
    vecs.push_back(mk(0, 0, 0, 32'h20C, F_EMP, 0));
    // call+ret together: ret wins; stall masks call/ret; redirect masks call
    vecs.push_back(mk(K_CAL, 0, 32'h700, 32'h700, 0, 0));
    vecs.push_back(mk(K_CAL | K_RET, 0, 32'h900, 32'h210, F_EMP, 0));
    vecs.push_back(mk(K_STL | K_CAL, 0, 32'h900, 32'h210, F_EMP, 0));
    vecs.push_back(mk(K_STL | K_RET, 0, 0, 32'h210, F_EMP, 0));
    vecs.push_back(mk(K_RED | K_CAL, 32'h80, 32'h900, 32'h80, F_EMP, 0));
    // Wrap modulo 2^32
    vecs.push_back(mk(K_RED, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, F_EMP, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0, F_EMP, 0));
    // Halt / resume, inputs ignored while halted, reset mid-halt
    vecs.push_back(mk(K_RED, 32'h8, 0, 32'h8, F_EMP, 0));
    vecs.push_back(mk(K_HLT, 0, 0, 32'hC, F_HLT | F_EMP, 0));
    vecs.push_back(mk(K_RED, 32'h40, 0, 32'hC, F_HLT | F_EMP, 0));
    vecs.push_back(mk(K_CAL, 0, 32'h900, 32'hC, F_HLT | F_EMP, 0));
    vecs.push_back(mk(K_RET, 0, 0, 32'hC, F_HLT | F_EMP, 0));
    vecs.push_back(mk(K_RES, 0, 0, 32'hC, F_EMP, 0));
    vecs.push_back(mk(0, 0, 0, 32'h10, F_EMP, 0));
    vecs.push_back(mk(K_HLT, 0, 0, 32'h14, F_HLT | F_EMP, 0));
    vecs.push_back(mk(K_RST, 0, 0, 32'h0, F_EMP, 0));
    // Misaligned redirect: sticky fault until reset
    vecs.push_back(mk(K_RED, 32'h42, 0, 32'h0, F_MIS | F_EMP, 32'h42));
    vecs.push_back(mk(K_RED, 32'h100, 0, 32'h0, F_MIS | F_EMP, 32'h42));
    vecs.push_back(mk(K_RES, 0, 0, 32'h0, F_MIS | F_EMP, 32'h42));
    vecs.push_back(mk(K_RST, 0, 0, 32'h0, F_EMP, 0));
    // Misaligned call target: fault, no push
    vecs.push_back(mk(K_CAL, 0, 32'h103, 32'h0, F_MIS | F_EMP, 32'h103));
    vecs.push_back(mk(K_RST, 0, 0, 32'h0, F_EMP, 0));

    foreach (vecs[i]) apply(i, vecs[i]);

    // pc_valid is combinational on stall and state
    @(negedge clk);
    drive(0, '0, '0);
    #1 check("pc_valid run", 32'(bus.pc_valid), 32'd1);
    bus.stall = 1'b1;
    #1 check("pc_valid stall", 32'(bus.pc_valid), 32'd0);
    bus.stall = 1'b0;
    bus.halt_req = 1'b1;
    @(posedge clk);
    #1;
    bus.halt_req = 1'b0;
    check("pc_valid halted", 32'(bus.pc_valid), 32'd0);
    check("halted flag", 32'(bus.halted), 32'd1);
    @(negedge clk);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h6;
    @(negedge clk);
    check("pc_valid halted hold", 32'(bus.pc_valid), 32'd0);
    check("pc halted hold", bus.pc, 32'h4);
    drive(K_RST, '0, '0);
    @(posedge clk);
    #1 drive(0, '0, '0);
    check("pc_valid after rst", 32'(bus.pc_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
